// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-side handshake bundle for the TX arbiter.
interface uart_tx_arbiter_if;
    logic [1:0]  valid_i;
    logic [15:0] data_i;
    logic [1:0]  last_i;
    logic [1:0]  ready_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        last_o;
    logic        ready_i;
    logic [1:0]  grant_o;
    logic        timeout_o;
    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, last_o, grant_o, timeout_o
    );
    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, last_o, grant_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin share of one UART TX byte stream between two requesters.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W = 16
) (
    input logic clk_i,
    input logic reset_ni,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    state_t           state_q;
    logic             owner_q, last_grant_q, valid_q, last_q, timeout_q;
    logic [7:0]       data_q;
    logic [1:0]       grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic             can_take, acc, req, expire;
    logic [7:0]       sel_data;
    always_comb begin
        can_take = state_q == BUSY && (!valid_q || bus.ready_i);
        bus.ready_o = can_take ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        acc = can_take && bus.valid_i[owner_q];
        sel_data = owner_q ? bus.data_i[15:8] : bus.data_i[7:0];
        req = &bus.valid_i ? !last_grant_q : bus.valid_i[1];
        expire = TIMEOUT_CYCLES != 0 && cnt_q == LIMIT;
    end
    assign bus.valid_o = valid_q;
    assign bus.data_o = data_q;
    assign bus.last_o = last_q;
    assign bus.grant_o = grant_q;
    assign bus.timeout_o = timeout_q;
    // Output stage drains on its own; the FSM only decides who may refill it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_grant_q <= 1'b1;
            valid_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            grant_q <= 2'b00;
            timeout_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            timeout_q <= 1'b0;
            if (acc) begin
                valid_q <= 1'b1;
                data_q <= sel_data;
                last_q <= bus.last_i[owner_q];
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (|bus.valid_i) begin
                    state_q <= BUSY;
                    owner_q <= req;
                    grant_q <= req ? 2'b10 : 2'b01;
                end
            end else if (acc) begin
                cnt_q <= '0;
                if (bus.last_i[owner_q]) begin
                    state_q <= IDLE;
                    last_grant_q <= owner_q;
                    grant_q <= 2'b00;
                end
            end else if (expire) begin
                state_q <= IDLE;
                timeout_q <= 1'b1;
                last_grant_q <= owner_q;
                grant_q <= 2'b00;
                cnt_q <= '0;
            end else begin
                cnt_q <= TIMEOUT_CYCLES == 0 ? '0 : cnt_q + 1'b1;
            end
        end
    end
endmodule
